sr_flag_arb: RTL and testbench

SR_FLAG_ARB -- requirements
Module: sr_flag_arb

---
 rtl/sr_arb_pkg.sv | 16 +
 rtl/sr_flag_arb_cell.sv | 22 ++
 rtl/sr_flag_arb.sv | 146 ++++++++++++++
 tb/tb_sr_flag_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_arb_pkg.sv
// Shared encodings for the SR flag arbiter: requester commands and sweep FSM states.
package sr_arb_pkg;

   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_CLR  = 2'b01,
      CMD_SET  = 2'b10,
      CMD_ILL  = 2'b11
   } cmd_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

endpackage

// File: rtl/sr_flag_arb_cell.sv
// Single SR flag cell; the parent guarantees s and r are never high together.
module sr_cell (
   input  logic clk,
   input  logic rst,
   input  logic s,
   input  logic r,
   output logic q,
   output logic qbar
);

   logic q_q;

   always_ff @(posedge clk) begin
      if (rst)    q_q <= 1'b0;
      else if (s) q_q <= 1'b1;
      else if (r) q_q <= 1'b0;
   end

   assign q    = q_q;
   assign qbar = ~q_q;

endmodule

// File: rtl/sr_flag_arb.sv
// Round-robin arbiter serialising set/clear requests onto an array of SR flags,
// with a clear-all sweep. Define SRARB_ERR_EN to enable the sticky err output.
module sr_flag_arb
   import sr_arb_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int NFLAGS = 8,
   localparam int IDXW   = $clog2(NFLAGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [2*NREQ-1:0]    req_cmd,
   input  logic [IDXW*NREQ-1:0] req_idx,
   output logic [NREQ-1:0]      grant,
   input  logic                 clr_all,
   output logic                 busy,
   output logic [NFLAGS-1:0]    q,
   output logic [NFLAGS-1:0]    qbar,
   output logic                 err
);

   localparam int RRW = $clog2(NREQ);

   state_e              state_q, state_d;
   logic [IDXW-1:0]     cnt_q, cnt_d;
   logic [RRW-1:0]      rr_q, rr_d;

   logic [1:0]          cmd_a [NREQ];
   logic [IDXW-1:0]     idx_a [NREQ];
   logic                gnt_any;
   logic [RRW-1:0]      gidx;
   cmd_e                sel_cmd;
   logic [IDXW-1:0]     sel_idx;
   logic [NFLAGS-1:0]   s_vec, r_vec;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign cmd_a[i] = req_cmd[2*i +: 2];
      assign idx_a[i] = req_idx[IDXW*i +: IDXW];
   end

   // Search upward from rr with wrap; candidates are kept below NREQ.
   always_comb begin
      int j;
      logic [RRW-1:0] cand;
      grant   = '0;
      gnt_any = 1'b0;
      gidx    = '0;
      j       = 0;
      cand    = '0;
      if (!rst && state_q == ST_IDLE) begin
         for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            cand = RRW'(j);
            if (!gnt_any && req_valid[cand]) begin
               gnt_any = 1'b1;
               gidx    = cand;
            end
         end
      end
      if (gnt_any) grant[gidx] = 1'b1;
   end

   assign sel_cmd = cmd_e'(cmd_a[gidx]);
   assign sel_idx = idx_a[gidx];

   always_comb begin
      s_vec = '0;
      r_vec = '0;
      if (state_q == ST_SWEEP) begin
         r_vec[cnt_q] = 1'b1;
      end else if (gnt_any) begin
         case (sel_cmd)
            CMD_SET: s_vec[sel_idx] = 1'b1;
            CMD_CLR: r_vec[sel_idx] = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_all) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end
         end
         ST_SWEEP: begin
            if (cnt_q == IDXW'(NFLAGS-1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDXW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (gnt_any) rr_d = (gidx == RRW'(NREQ-1)) ? '0 : gidx + RRW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
      end
   end

`ifdef SRARB_ERR_EN
   logic err_q, err_d;

   assign err_d = err_q | (gnt_any && sel_cmd == CMD_ILL);

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy = (state_q == ST_SWEEP);

   for (genvar f = 0; f < NFLAGS; f++) begin : g_cell
      sr_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .s    (s_vec[f]),
         .r    (r_vec[f]),
         .q    (q[f]),
         .qbar (qbar[f])
      );
   end

endmodule

// File: tb/tb_sr_flag_arb.sv
// Bench for sr_flag_arb: directed scenarios then randomized traffic against a flag-array model.
module tb_sr_flag_arb;

   localparam int NREQ   = 4;
   localparam int NFLAGS = 8;
   localparam int IDXW   = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [2*NREQ-1:0]    req_cmd;
   logic [IDXW*NREQ-1:0] req_idx;
   logic [NREQ-1:0]      grant;
   logic                 clr_all;
   logic                 busy;
   logic [NFLAGS-1:0]    q, qbar;
   logic                 err;

   always #5 clk = ~clk;

   sr_flag_arb #(.NREQ(NREQ), .NFLAGS(NFLAGS)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
      .req_idx(req_idx), .grant(grant), .clr_all(clr_all), .busy(busy),
      .q(q), .qbar(qbar), .err(err)
   );

   int vectors = 0, miscompares = 0;

   // reference model: flag array, pointer, sticky error, clears still owed by a sweep
   bit [NFLAGS-1:0] m_q;
   int              m_rr;
   bit              m_err;
   int              m_left;

`ifdef SRARB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (rst || m_left > 0) return -1;
      for (int k = 0; k < NREQ; k++)
         if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_q = '0; m_rr = 0; m_err = 1'b0; m_left = 0;
   endtask

   // Inputs are set before the call (at the falling edge); returns observed grant and model grant index.
   task automatic step(output logic [NREQ-1:0] gobs, output int gi);
      logic [NREQ-1:0]   eg;
      logic [NFLAGS-1:0] nq;
      int c, ix;
      #1;
      gi = model_grant();
      eg = '0;
      if (gi >= 0) eg[gi] = 1'b1;
      nq = ~m_q;
      gobs = grant;
      chk("grant", grant, eg);
      chk("q", q, m_q);
      chk("qbar", qbar, nq);
      chk("busy", busy, m_left > 0);
      chk("err", err, m_err);
      @(posedge clk);
      if (rst) model_reset();
      else if (m_left > 0) begin
         m_q[NFLAGS - m_left] = 1'b0;
         m_left--;
      end else begin
         if (gi >= 0) begin
            c  = req_cmd[2*gi +: 2];
            ix = req_idx[IDXW*gi +: IDXW];
            if (c == 2) m_q[ix] = 1'b1;
            if (c == 1) m_q[ix] = 1'b0;
            if (c == 3 && ERR_EN) m_err = 1'b1;
            m_rr = (gi + 1) % NREQ;
         end
         if (clr_all) m_left = NFLAGS;
      end
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input bit v, input int c, input int ix);
      req_valid[i]             = v;
      req_cmd[2*i +: 2]        = c[1:0];
      req_idx[IDXW*i +: IDXW]  = ix[IDXW-1:0];
   endtask

   task automatic fill_all();
      logic [NREQ-1:0] g; int gi;
      for (int f = 0; f < NFLAGS; f++) begin
         set_req(0, 1, 2, f);
         step(g, gi);
      end
      set_req(0, 0, 0, 0);
   endtask

   logic [NREQ-1:0]   gobs;
   logic [NREQ-1:0]   eg1;
   logic [NFLAGS-1:0] eq8;
   int                gi;
   bit                pend [NREQ];

   initial begin
      rst = 1'b1; clr_all = 1'b0; req_valid = '0; req_cmd = '0; req_idx = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      step(gobs, gi);
      chk("rst_grant", gobs, 0);
      chk("rst_q", q, 8'h00);
      chk("rst_qbar", qbar, 8'hFF);
      rst = 1'b0;

      // single set on idx 3
      set_req(0, 1, 2, 3);
      step(gobs, gi);
      chk("r35_grant", gobs, 4'b0001);
      set_req(0, 0, 0, 0);
      chk("r35_q", q, 8'h08);
      chk("r35_qbar", qbar, 8'hF7);

      // rotation from rr=0
      rst = 1'b1; step(gobs, gi); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0);
      for (int k = 0; k < NREQ; k++) begin
         step(gobs, gi);
         eg1 = '0; eg1[k] = 1'b1;
         chk("r36_grant", gobs, eg1);
      end
      step(gobs, gi);
      chk("r36_wrap", gobs, 4'b0001);
      for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0);

      // full sweep with requesters waiting; a second clr_all mid-sweep is ignored
      fill_all();
      chk("r37_full", q, 8'hFF);
      clr_all = 1'b1; step(gobs, gi); clr_all = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0);
      for (int k = 0; k < NFLAGS; k++) begin
         chk("r37_busy", busy, 1'b1);
         clr_all = (k == 3);
         step(gobs, gi);
         chk("r37_grant", gobs, 0);
         eq8 = 8'hFF << (k + 1);
         chk("r37_q", q, eq8);
      end
      clr_all = 1'b0;
      chk("r37_done", busy, 1'b0);
      for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0);
      step(gobs, gi);

      // illegal command leaves the flag alone
      set_req(0, 1, 2, 2); step(gobs, gi);
      set_req(0, 1, 3, 2); step(gobs, gi);
      set_req(0, 0, 0, 0);
      chk("r38_q", q, 8'h04);
      chk("r38_err", err, ERR_EN);

      // set and clr_all in the same cycle
      set_req(1, 1, 2, 7); clr_all = 1'b1;
      step(gobs, gi);
      set_req(1, 0, 0, 0); clr_all = 1'b0;
      chk("r39_q7", q[7], 1'b1);
      chk("r39_busy", busy, 1'b1);
      repeat (NFLAGS) step(gobs, gi);
      chk("r39_q", q, 8'h00);

      // reset during the third sweep cycle
      fill_all();
      clr_all = 1'b1; step(gobs, gi); clr_all = 1'b0;
      step(gobs, gi);
      step(gobs, gi);
      chk("r40_mid", q, 8'hFC);
      rst = 1'b1; step(gobs, gi); rst = 1'b0;
      chk("r40_q", q, 8'h00);
      chk("r40_busy", busy, 1'b0);
      set_req(0, 1, 0, 0); step(gobs, gi);
      chk("r40_idle", gobs, 4'b0001);
      set_req(0, 0, 0, 0);

      // randomized traffic: each requester holds its request until granted
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
               pend[i] = 1'b1;
               set_req(i, 1, $urandom_range(3, 0), $urandom_range(NFLAGS-1, 0));
            end
         clr_all = ($urandom_range(15, 0) == 0);
         rst     = ($urandom_range(99, 0) == 0);
         step(gobs, gi);
         if (gi >= 0) begin
            pend[gi] = 1'b0;
            set_req(gi, 0, 0, 0);
         end
      end
      rst = 1'b0; clr_all = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
